traffic_light_ctrl: RTL and testbench

Highway/farm-road intersection traffic-light controller. It is a Moore FSM with a dwell-cycle timer that drives three lamps per road, and it yields to the farm road only when a farm-road car sensor requests it. The block is standalone, clocked by the system clock, and its outputs feed the lamp drivers directly.

---
 rtl/traffic_light_ctrl.sv | 108 ++++++++++
 tb/tb_traffic_light_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Highway/farm-road traffic-light controller.
// Moore FSM (HG -> HY -> FG -> FY) with a saturating dwell counter. It yields to the farm road
// only when the farm-road car sensor requests it.
//
// Optional build macro CAR_LATCH_EN: when defined, a car seen at any edge during highway green is
// remembered in a sticky flag. The flag is cleared on entry to highway yellow.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset (forces HG, cnt=0)
//   c          farm-road car sensor, 1 = car waiting, sampled on clk
//   HL_GREEN/HL_YELLOW/HL_RED  highway lamps
//   FL_GREEN/FL_YELLOW/FL_RED  farm-road lamps
module traffic_light_ctrl #(
  parameter int unsigned LONG_CYC  = 8,
  parameter int unsigned SHORT_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic c,
  output logic HL_GREEN,
  output logic HL_YELLOW,
  output logic HL_RED,
  output logic FL_GREEN,
  output logic FL_YELLOW,
  output logic FL_RED
);

  localparam int unsigned CntW = (LONG_CYC > 2) ? $clog2(LONG_CYC) : 1;
  localparam logic [CntW-1:0] LongMax  = CntW'(LONG_CYC - 1);
  localparam logic [CntW-1:0] ShortMax = CntW'(SHORT_CYC - 1);

  typedef enum logic [1:0] {
    StHg = 2'b00,
    StHy = 2'b01,
    StFg = 2'b10,
    StFy = 2'b11
  } state_e;

  state_e          present_state_q, present_state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hg_req;

`ifdef CAR_LATCH_EN
  logic flag_q, flag_d;

  assign hg_req = c | flag_q;

  always_comb begin
    flag_d = flag_q;
    if (present_state_q == StHg && c) flag_d = 1'b1;
    // Entering HY clears the flag; this wins over a same-edge set.
    if (present_state_q != StHy && present_state_d == StHy) flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flag_q <= 1'b0;
    else      flag_q <= flag_d;
  end
`else
  assign hg_req = c;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      present_state_q <= StHg;
      cnt_q           <= '0;
    end else begin
      present_state_q <= present_state_d;
      cnt_q           <= cnt_d;
    end
  end

  always_comb begin
    present_state_d = present_state_q;
    unique case (present_state_q)
      StHg: if (hg_req && cnt_q >= LongMax)    present_state_d = StHy;
      StHy: if (cnt_q == ShortMax)             present_state_d = StFg;
      StFg: if (!c || cnt_q == LongMax)        present_state_d = StFy;
      StFy: if (cnt_q == ShortMax)             present_state_d = StHg;
      default:                                 present_state_d = StHg;
    endcase
  end

  // Dwell counter restarts on every state change and saturates at LONG_CYC-1.
  always_comb begin
    cnt_d = cnt_q;
    if (present_state_d != present_state_q) cnt_d = '0;
    else if (cnt_q != LongMax)              cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    HL_GREEN  = 1'b0;
    HL_YELLOW = 1'b0;
    HL_RED    = 1'b0;
    FL_GREEN  = 1'b0;
    FL_YELLOW = 1'b0;
    FL_RED    = 1'b0;
    unique case (present_state_q)
      StHg: begin HL_GREEN  = 1'b1; FL_RED    = 1'b1; end
      StHy: begin HL_YELLOW = 1'b1; FL_RED    = 1'b1; end
      StFg: begin HL_RED    = 1'b1; FL_GREEN  = 1'b1; end
      StFy: begin HL_RED    = 1'b1; FL_YELLOW = 1'b1; end
      default: begin HL_GREEN = 1'b1; FL_RED = 1'b1; end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: a cycle model pushes the expected lamp vector when
// each c value is driven; it is popped and compared one edge later.
module tb_traffic_light_ctrl;

  localparam int unsigned LongCyc  = 8;
  localparam int unsigned ShortCyc = 2;
`ifdef CAR_LATCH_EN
  localparam bit Latch = 1'b1;
`else
  localparam bit Latch = 1'b0;
`endif

  // Lamp vector {HL_G, HL_Y, HL_R, FL_G, FL_Y, FL_R}
  localparam logic [5:0] LHg = 6'b100_001;
  localparam logic [5:0] LHy = 6'b010_001;
  localparam logic [5:0] LFg = 6'b001_100;
  localparam logic [5:0] LFy = 6'b001_010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic c   = 1'b0;
  logic hl_green, hl_yellow, hl_red, fl_green, fl_yellow, fl_red;
  logic [5:0] lamps;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_q[$];

  // Reference model: state code and unbounded dwell count.
  int m_st   = 0;
  int m_dw   = 0;
  bit m_flag = 1'b0;

  traffic_light_ctrl #(
    .LONG_CYC (LongCyc),
    .SHORT_CYC(ShortCyc)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .c        (c),
    .HL_GREEN (hl_green),
    .HL_YELLOW(hl_yellow),
    .HL_RED   (hl_red),
    .FL_GREEN (fl_green),
    .FL_YELLOW(fl_yellow),
    .FL_RED   (fl_red)
  );

  assign lamps = {hl_green, hl_yellow, hl_red, fl_green, fl_yellow, fl_red};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] lamp_of(input int st);
    case (st)
      0:       return LHg;
      1:       return LHy;
      2:       return LFg;
      default: return LFy;
    endcase
  endfunction

  task automatic model_reset();
    m_st   = 0;
    m_dw   = 0;
    m_flag = 1'b0;
  endtask

  task automatic model_edge(input logic cv);
    int  nxt;
    bit  req;
    nxt = m_st;
    req = cv || (Latch && m_flag);
    case (m_st)
      0: if (req && m_dw >= int'(LongCyc) - 1) nxt = 1;
      1: if (m_dw == int'(ShortCyc) - 1) nxt = 2;
      2: if (!cv || m_dw == int'(LongCyc) - 1) nxt = 3;
      default: if (m_dw == int'(ShortCyc) - 1) nxt = 0;
    endcase
    if (m_st == 0 && cv) m_flag = 1'b1;
    if (nxt == 1 && m_st != 1) m_flag = 1'b0;
    m_dw = (nxt != m_st) ? 0 : m_dw + 1;
    m_st = nxt;
  endtask

  // Called at posedge+1: drive c, predict, advance one edge, compare.
  task automatic step(input logic cv);
    logic [5:0] e;
    c = cv;
    model_edge(cv);
    exp_q.push_back(lamp_of(m_st));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("lamps", 32'(lamps), 32'(e));
    check_eq("inv_hl_onehot", 32'($countones(lamps[5:3])), 32'd1);
    check_eq("inv_fl_onehot", 32'($countones(lamps[2:0])), 32'd1);
    check_eq("inv_one_red", 32'(lamps[3] | lamps[0]), 32'd1);
  endtask

  task automatic sync_reset();
    rst = 1'b0;
    c   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    // 1. Reset held with clock running
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_lamps", 32'(lamps), 32'(LHg));
    check_eq("reset_cnt", 32'(dut.cnt_q), 32'd0);
    rst = 1'b1;
    model_reset();

    // 2. c held high: HG 8, HY 2, FG 8, FY 2, HG 8, then HY
    repeat (2 * LongCyc + 2 * ShortCyc + LongCyc + 1) step(1'b1);

    // 1b. Asynchronous reset in FG, observed before any edge
    sync_reset();
    repeat (LongCyc + ShortCyc + 1) step(1'b1);
    check_eq("pre_async_fg", 32'(lamps), 32'(LFg));
    #3;
    rst = 1'b0;
    #1;
    check_eq("async_reset_lamps", 32'(lamps), 32'(LHg));
    check_eq("async_reset_cnt", 32'(dut.cnt_q), 32'd0);
    @(posedge clk);
    #1;
    check_eq("reset_hold_lamps", 32'(lamps), 32'(LHg));
    rst = 1'b1;
    model_reset();

    // 3. c low for 50 cycles: HG forever, counter saturates
    repeat (50) step(1'b0);
    check_eq("cnt_saturate", 32'(dut.cnt_q), 32'(LongCyc - 1));

    // 4. c low 20 cycles, then high: HY next edge, FG; drop c at FG cycle 3
    sync_reset();
    repeat (20) step(1'b0);
    step(1'b1);
    check_eq("t4_hy_next_edge", 32'(lamps), 32'(LHy));
    repeat (ShortCyc) step(1'b1);
    check_eq("t4_fg", 32'(lamps), 32'(LFg));
    repeat (2) step(1'b1);
    step(1'b0);
    check_eq("t4_fy_after_drop", 32'(lamps), 32'(LFy));
    repeat (ShortCyc + 4) step(1'b0);

    // 5. Single-cycle pulse at HG cycle 2
    sync_reset();
    step(1'b0);
    step(1'b0);
    step(1'b1);
    repeat (LongCyc - 3) step(1'b0);
    step(1'b0);
`ifdef CAR_LATCH_EN
    check_eq("t5_latched_hy", 32'(lamps), 32'(LHy));
    check_eq("t5_flag_clr", 32'(dut.flag_q), 32'd0);
`else
    check_eq("t5_no_latch_hg", 32'(lamps), 32'(LHg));
`endif
    repeat (15) step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
